uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each received word and its frame-error flag when the receiver's `new_data` level rises, and stores them in a circular FIFO. The bus side drains the FIFO with a read strobe. The block also tracks fill level, a programmable threshold interrupt and a sticky overrun flag.

Parameters:
ADDR_W, 4, FIFO address width.
DEPTH, 16, number of entries. Must equal 2**ADDR_W.
DATA_W, 16, word width. Matches the receiver `data_out` width.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-low reset; rst=0 at a clk edge resets the block
rx_data  input  DATA_W  received word from the receiver
rx_frame_err  input  1  frame error of the current word; sampled together with rx_data
rx_new_data  input  1  receiver "word ready" level; may stay high for many cycles
rd_en  input  1  read strobe, one entry per cycle high
flush  input  1  discard all contents
threshold  input  ADDR_W+1  interrupt level; 0 disables the interrupt
overrun_clr  input  1  clears overrun
rd_data  output  DATA_W  registered read word
rd_frame_err  output  1  frame error stored with rd_data
rd_valid  output  1  one-cycle pulse: rd_data/rd_frame_err updated
empty  output  1  level==0
full  output  1  level==DEPTH
level  output  ADDR_W+1  current entry count, 0..DEPTH
thresh_irq  output  1  level>=threshold and threshold!=0
overrun  output  1  sticky: a word was dropped

Behaviour:
- Reset (rst=0 at a clk edge), all registers cleared:
  - wr_ptr=0, rd_ptr=0, level=0, overrun=0, rd_valid=0.
  - rd_data=0, rd_frame_err=0, edge register nd_q=0.
  - Resulting outputs: empty=1, full=0, thresh_irq=0.
  - Memory contents are not reset.
  - Reset mid-operation discards everything; no partial write or read completes.
- Write detect:
  - nd_q <= rx_new_data every cycle.
  - wr_stb = rx_new_data & ~nd_q. This gives exactly one write per rising edge, however long the level stays high.
  - rx_data and rx_frame_err are sampled in the wr_stb cycle.
- Write path, when wr_stb:
  - If not full: mem[wr_ptr] <= {rx_frame_err, rx_data}; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - If full and no accepted read this cycle: word dropped, overrun <= 1, pointers unchanged.
- Read path, rd_en while not empty:
  - rd_data/rd_frame_err <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, wrapping.
  - rd_valid=1 in the next cycle. Read latency is 1 cycle.
  - rd_en while empty is ignored: rd_valid=0, rd_data holds.
- Simultaneous events:
  - Write+read while full: both accepted, level unchanged, no overrun.
  - Write+read while empty: write accepted, read ignored, level becomes 1.
  - Write+read otherwise: both accepted, level unchanged.
- Level:
  - +1 on accepted write only; -1 on accepted read only; otherwise unchanged.
  - Never exceeds DEPTH and never underflows.
- Flush:
  - Sets wr_ptr=rd_ptr=0 and level=0 next cycle.
  - Overrides any wr_stb/rd_en in the same cycle: that write is lost without setting overrun, and that read produces no rd_valid.
  - Does not clear overrun; does not alter rd_data.
- Overrun:
  - Set by a dropped write; cleared by overrun_clr.
  - If set and clear coincide, set wins.
- Status outputs:
  - empty, full and thresh_irq are combinational from the registered level, so they are valid the cycle after the causing event.
  - thresh_irq is a level signal, not a pulse.
  - Threshold values above DEPTH are legal; thresh_irq then never asserts.

Test Plan:
1. Reset then write: reset with rst=0 for 2 cycles; then raise rx_new_data with rx_data=0x0041 and frame_err=0, holding it 50 cycles -> level=1 (one write only), empty=0. Then rd_en one cycle -> rd_valid pulse next cycle, rd_data=0x0041, rd_frame_err=0, level=0, empty=1.
2. Fill, overrun and order: write 17 words 0x0000..0x0010 with no reads -> full=1 and level=16 after the 16th word; the 17th word is dropped and overrun=1. Read 16 times -> data 0x0000..0x000F in order. Pulse overrun_clr -> overrun=0.
3. Wrap and simultaneous ops:
   - Write 10, read 10, then write 12 -> data correct across pointer wrap.
   - With the FIFO full, assert rd_en in the same cycle as wr_stb -> level stays 16, overrun stays 0.
   - With the FIFO empty, same coincidence -> level=1, no rd_valid.
4. Threshold: threshold=4. Writes 1..3 -> thresh_irq=0. 4th write -> thresh_irq=1 the cycle after. One read -> thresh_irq=0. Set threshold=0 -> thresh_irq=0 at any level.
5. Flush: with level=7, assert flush in the same cycle as a wr_stb and rd_en -> next cycle level=0, empty=1, no rd_valid, overrun unchanged. A subsequent write followed by a read returns the new word.
6. Frame error and reset mid-fill: write 0x00FF with rx_frame_err=1 -> a later read gives rd_frame_err=1. With level=5, drive rst=0 for 1 cycle -> level=0, overrun=0, rd_data=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer downstream of a UART receiver.
// Captures {frame_err, data} on each rising edge of rx_new_data into a circular
// FIFO that the bus side drains with rd_en. Reports fill level, a programmable
// threshold interrupt and a sticky overrun flag.
//
// Ports:
//   clk, rst          - clock; synchronous active-low reset
//   rx_data           - received word
//   rx_frame_err      - frame error of the received word
//   rx_new_data       - receiver word-ready level (one write per rising edge)
//   rd_en             - read strobe, one entry per cycle
//   flush             - discard all contents
//   threshold         - interrupt level, 0 disables
//   overrun_clr       - clear the sticky overrun flag
//   rd_data           - registered read word
//   rd_frame_err      - frame error stored with rd_data
//   rd_valid          - one-cycle pulse when rd_data/rd_frame_err update
//   empty, full       - level == 0 / level == DEPTH
//   level             - entry count 0..DEPTH
//   thresh_irq        - level >= threshold, threshold != 0
//   overrun           - sticky, a word was dropped
module uart_rx_fifo #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,  // must equal 2**ADDR_W
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_frame_err,
  input  logic              rx_new_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [ADDR_W:0]   threshold,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_frame_err,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              thresh_irq,
  output logic              overrun
);

  localparam logic [ADDR_W:0]   FullLvl = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   LvlOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PtrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              nd_q, overrun_q, overrun_d, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_frame_err_q;
  logic              wr_stb, wr_acc, rd_acc, drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == FullLvl);

  // One write per rising edge of the receiver's level.
  assign wr_stb = rx_new_data & ~nd_q;
  // Reading a full FIFO in the same cycle frees the slot being written;
  // the read register samples the old contents at the same edge.
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_stb & ~flush & (~full | rd_acc);
  assign drop   = wr_stb & ~flush & full & ~rd_acc;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
      if (wr_acc && !rd_acc) begin
        level_d = level_q + LvlOne;
      end else if (rd_acc && !wr_acc) begin
        level_d = level_q - LvlOne;
      end
    end
    // Set beats clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      overrun_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_frame_err_q <= 1'b0;
      nd_q           <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_acc;
      nd_q       <= rx_new_data;
      if (rd_acc) begin
        rd_data_q      <= mem[rd_ptr_q][DATA_W-1:0];
        rd_frame_err_q <= mem[rd_ptr_q][DATA_W];
      end
    end
  end

  // Storage is not reset, but no write lands while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem[wr_ptr_q] <= {rx_frame_err, rx_data};
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_frame_err = rd_frame_err_q;
  assign rd_valid     = rd_valid_q;
  assign level        = level_q;
  assign overrun      = overrun_q;
  assign thresh_irq   = (threshold != '0) && (level_q >= threshold);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a table of directed vectors, hand-written
// corner sequences and a randomized run, all compared against a queue-based model.
module tb_uart_rx_fifo;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_frame_err = 1'b0;
  logic              rx_new_data = 1'b0;
  logic              rd_en = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W:0]   threshold = '0;
  logic              overrun_clr = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_frame_err, rd_valid, empty, full, thresh_irq, overrun;
  logic [ADDR_W:0]   level;

  uart_rx_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
    .rx_new_data(rx_new_data), .rd_en(rd_en), .flush(flush), .threshold(threshold),
    .overrun_clr(overrun_clr), .rd_data(rd_data), .rd_frame_err(rd_frame_err),
    .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
    .thresh_irq(thresh_irq), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {frame_err, data} entries plus output registers.
  logic [DATA_W:0] mq[$];
  bit              m_ovr, m_rv, m_nd;
  logic [DATA_W:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, nd, input logic [DATA_W-1:0] d,
                            input bit fe, rd, fl, clr);
    bit wr, set;
    if (!r) begin
      mq.delete();
      m_ovr = 0; m_rv = 0; m_nd = 0; m_rd = '0;
      return;
    end
    wr   = nd && !m_nd;
    m_nd = nd;
    m_rv = 0;
    set  = 0;
    if (fl) begin
      mq.delete();
    end else begin
      if (rd && mq.size() > 0) begin
        m_rd = mq.pop_front();
        m_rv = 1;
      end
      if (wr) begin
        if (mq.size() < DEPTH) mq.push_back({fe, d});
        else set = 1;
      end
    end
    if (set) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic compare_model(input string tag);
    int lvl;
    lvl = mq.size();
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
    check({tag, ".full"}, 32'(full), 32'(lvl == DEPTH));
    check({tag, ".irq"}, 32'(thresh_irq), 32'((threshold != 0) && (lvl >= int'(threshold))));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
    check({tag, ".rd_word"}, 32'({rd_frame_err, rd_data}), 32'(m_rd));
  endtask

  task automatic cycle(input bit r, nd, input logic [DATA_W-1:0] d, input bit fe, rd, fl,
                       clr, input string tag);
    rst = r; rx_new_data = nd; rx_data = d; rx_frame_err = fe;
    rd_en = rd; flush = fl; overrun_clr = clr;
    @(posedge clk);
    model_step(r, nd, d, fe, rd, fl, clr);
    #1;
    compare_model(tag);
  endtask

  task automatic wr_word(input logic [DATA_W-1:0] d, input bit fe, input string tag);
    cycle(1, 1, d, fe, 0, 0, 0, tag);
    cycle(1, 0, d, fe, 0, 0, 0, tag);
  endtask

  task automatic rd_word(input string tag);
    cycle(1, 0, '0, 0, 1, 0, 0, tag);
  endtask

  typedef struct {
    int              n;
    bit              r, nd, rd;
    logic [DATA_W-1:0] d;
    int              e_lvl;
    bit              e_empty, e_irq, e_rv;
    logic [DATA_W-1:0] e_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2,  0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000};
    vecs[1]  = '{50, 1, 1, 0, 16'h0041, 1, 0, 0, 0, 16'h0000};
    vecs[2]  = '{1,  1, 0, 1, 16'h0000, 0, 1, 0, 1, 16'h0041};
    vecs[3]  = '{1,  1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0041};
    vecs[4]  = '{1,  1, 1, 0, 16'h0001, 1, 0, 0, 0, 16'h0041};
    vecs[5]  = '{1,  1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0041};
    vecs[6]  = '{1,  1, 1, 0, 16'h0002, 2, 0, 0, 0, 16'h0041};
    vecs[7]  = '{1,  1, 0, 0, 16'h0000, 2, 0, 0, 0, 16'h0041};
    vecs[8]  = '{1,  1, 1, 0, 16'h0003, 3, 0, 0, 0, 16'h0041};
    vecs[9]  = '{1,  1, 0, 0, 16'h0000, 3, 0, 0, 0, 16'h0041};
    vecs[10] = '{1,  1, 1, 0, 16'h0004, 4, 0, 1, 0, 16'h0041};
    vecs[11] = '{1,  1, 0, 1, 16'h0000, 3, 0, 0, 1, 16'h0001};

    threshold = 5'd4;
    for (int i = 0; i < 12; i++) begin
      repeat (vecs[i].n) cycle(vecs[i].r, vecs[i].nd, vecs[i].d, 0, vecs[i].rd, 0, 0, "vec");
      check($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].e_lvl));
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d.irq", i), 32'(thresh_irq), 32'(vecs[i].e_irq));
      check($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
      check($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd));
    end

    // Fill, overrun and order.
    cycle(1, 0, '0, 0, 0, 1, 0, "t2_flush");
    for (int i = 0; i < 17; i++) begin
      wr_word(16'(i), 0, "t2_wr");
      if (i == 15) begin
        check("t2_full", 32'(full), 32'd1);
        check("t2_level16", 32'(level), 32'd16);
        check("t2_no_ovr_yet", 32'(overrun), 32'd0);
      end
    end
    check("t2_overrun", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) rd_word("t2_rd");
    check("t2_last_data", 32'(rd_data), 32'h000f);
    cycle(1, 0, '0, 0, 0, 0, 1, "t2_clr");
    check("t2_ovr_cleared", 32'(overrun), 32'd0);

    // Wrap and coincident operations.
    for (int i = 0; i < 10; i++) wr_word(16'h0100 + 16'(i), 0, "t3_wr10");
    for (int i = 0; i < 10; i++) rd_word("t3_rd10");
    for (int i = 0; i < 12; i++) wr_word(16'h0200 + 16'(i), 0, "t3_wr12");
    for (int i = 0; i < 12; i++) rd_word("t3_rd12");
    check("t3_wrap_last", 32'(rd_data), 32'h020b);
    for (int i = 0; i < 16; i++) wr_word(16'h0300 + 16'(i), 0, "t3_fill");
    cycle(1, 1, 16'h0399, 0, 1, 0, 0, "t3_full_coinc");
    check("t3_full_coinc_level", 32'(level), 32'd16);
    check("t3_full_coinc_ovr", 32'(overrun), 32'd0);
    check("t3_full_coinc_data", 32'(rd_data), 32'h0300);
    cycle(1, 0, '0, 0, 0, 0, 0, "t3_idle");
    for (int i = 0; i < 16; i++) rd_word("t3_drain");
    check("t3_drain_last", 32'(rd_data), 32'h0399);
    cycle(1, 1, 16'h0400, 0, 1, 0, 0, "t3_empty_coinc");
    check("t3_empty_coinc_level", 32'(level), 32'd1);
    check("t3_empty_coinc_rv", 32'(rd_valid), 32'd0);
    cycle(1, 0, '0, 0, 0, 0, 0, "t3_idle2");

    // Threshold disabled.
    threshold = '0;
    for (int i = 0; i < 15; i++) wr_word(16'(i), 0, "t4_thr0");
    check("t4_thr0_irq", 32'(thresh_irq), 32'd0);

    // Flush overrides a coincident write and read.
    cycle(1, 1, 16'h0500, 0, 0, 0, 0, "t5_drop_set");
    cycle(1, 0, '0, 0, 0, 0, 0, "t5_idle");
    cycle(1, 1, 16'h0501, 0, 0, 0, 0, "t5_drop");
    cycle(1, 0, '0, 0, 0, 1, 0, "t5_flush0");
    for (int i = 0; i < 7; i++) wr_word(16'h0600 + 16'(i), 0, "t5_wr7");
    cycle(1, 1, 16'h0700, 0, 1, 1, 0, "t5_flush");
    check("t5_level", 32'(level), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_rv", 32'(rd_valid), 32'd0);
    check("t5_ovr_kept", 32'(overrun), 32'd1);
    cycle(1, 0, '0, 0, 0, 0, 0, "t5_idle2");
    wr_word(16'habcd, 0, "t5_new");
    rd_word("t5_rd");
    check("t5_new_data", 32'(rd_data), 32'habcd);

    // Frame error, then reset mid-fill.
    wr_word(16'h00ff, 1, "t6_fe");
    rd_word("t6_rd");
    check("t6_fe", 32'(rd_frame_err), 32'd1);
    check("t6_fe_data", 32'(rd_data), 32'h00ff);
    for (int i = 0; i < 5; i++) wr_word(16'h0800 + 16'(i), 0, "t6_wr5");
    cycle(0, 0, '0, 0, 0, 0, 0, "t6_rst");
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_ovr", 32'(overrun), 32'd0);
    check("t6_rst_data", 32'(rd_data), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) threshold = 5'($urandom_range(0, 18));
      cycle(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
